alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_mul_iter.sv | 73 +++++++
 rtl/alu_exec.sv | 118 +++++++++++
 tb/tb_alu_exec.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_exec execution block.
//   DATA_W      : datapath width (32)
//   SHAMT_W     : shift-amount width (5), taken from operand B low bits
//   alu_ctrl_e  : ALU control code encoding
//   state_e     : control FSM states (only used when ALU_MUL_EN is defined)
//   alu_simple(): single-cycle result for every code except MUL
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_XOR = 3'b001,
      ALU_SLL = 3'b010,
      ALU_SRA = 3'b011,
      ALU_SUB = 3'b100,
      ALU_MUL = 3'b101,
      ALU_ADD = 3'b110,
      ALU_RSV = 3'b111
   } alu_ctrl_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   // MUL and the reserved code both return zero here; the top substitutes
   // the real product for MUL in whichever way the build provides it.
   function automatic logic [DATA_W-1:0] alu_simple(
      input alu_ctrl_e         op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [SHAMT_W-1:0] sh;
      logic [DATA_W-1:0]  r;
      sh = b[SHAMT_W-1:0];
      r  = '0;
      case (op)
         ALU_AND: r = a & b;
         ALU_XOR: r = a ^ b;
         ALU_SLL: r = a << sh;
         ALU_SRA: r = DATA_W'($signed(a) >>> sh);
         ALU_SUB: r = a - b;
         ALU_ADD: r = a + b;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- 32-iteration shift-add multiplier (low 32 bits of A*B).
// Built only when ALU_MUL_EN is defined.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, aborts any run in progress
//   start_i : load operands and begin (counter cleared)
//   a_i/b_i : operands, sampled only when start_i is high
//   done_o  : high in the cycle whose rising edge performs the final iteration
//   prod_o  : product including that final iteration (valid while done_o)
module alu_mul_iter
   import alu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] prod_o
);

   logic [DATA_W-1:0]  mcand_q, mcand_d;
   logic [DATA_W-1:0]  mplier_q, mplier_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [DATA_W-1:0]  partial;

   // Accumulator value after this cycle's iteration.
   assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
   // The last iteration runs with the counter at 31; its wrap to 0 is the finish.
   assign done_o  = busy_q && (cnt_q == SHAMT_W'(DATA_W - 1));
   assign prod_o  = partial;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = partial;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (done_o) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_exec.sv
// alu_exec -- registered ALU execution stage with valid/ready handshake.
// Build option: define ALU_MUL_EN for a 32-cycle iterative multiplier
// (alu_mul_iter); otherwise MUL is a single-cycle combinational multiply.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   valid_i   : request, accepted on an edge where valid_i && ready_o
//   ready_o   : block can accept a request this cycle
//   ALUCtrl_i : operation code (alu_pkg::alu_ctrl_e)
//   data1_i   : operand A
//   data2_i   : operand B (bits [4:0] are the shift amount)
//   data_o    : registered result, held until the next result
//   valid_o   : one-cycle pulse marking a new data_o/zero_o
//   zero_o    : registered (data_o == 0)
module alu_exec
   import alu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        ALUCtrl_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              zero_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              zero_q, zero_d;
   logic              accept;
   alu_ctrl_e         op;

   assign op     = alu_ctrl_e'(ALUCtrl_i);
   assign accept = valid_i && ready_o;

`ifdef ALU_MUL_EN
   state_e            state_q, state_d;
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] mul_prod;

   assign ready_o = (state_q == ST_IDLE) && !rst_i;

   alu_mul_iter u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (mul_start),
      .a_i     (data1_i),
      .b_i     (data2_i),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_comb begin
      data_d    = data_q;
      valid_d   = 1'b0;
      state_d   = state_q;
      mul_start = 1'b0;
      if (accept) begin
         if (op == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
         end else begin
            data_d  = alu_simple(op, data1_i, data2_i);
            valid_d = 1'b1;
         end
      end else if (state_q == ST_MUL && mul_done) begin
         data_d  = mul_prod;
         valid_d = 1'b1;
         state_d = ST_IDLE;
      end
      zero_d = (data_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end
`else
   assign ready_o = !rst_i;

   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (accept) begin
         if (op == ALU_MUL) begin
            data_d = data1_i * data2_i;
         end else begin
            data_d = alu_simple(op, data1_i, data2_i);
         end
         valid_d = 1'b1;
      end
      zero_d = (data_d == '0);
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec -- directed, table-driven bench for alu_exec.
// Expectations follow the build: define ALU_MUL_EN for both files together.
module tb_alu_exec;

   localparam logic [2:0] C_AND = 3'b000;
   localparam logic [2:0] C_XOR = 3'b001;
   localparam logic [2:0] C_SLL = 3'b010;
   localparam logic [2:0] C_SRA = 3'b011;
   localparam logic [2:0] C_SUB = 3'b100;
   localparam logic [2:0] C_MUL = 3'b101;
   localparam logic [2:0] C_ADD = 3'b110;
   localparam logic [2:0] C_RSV = 3'b111;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic        clk_i;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  ALUCtrl_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        zero_o;

   int checks   = 0;
   int failures = 0;

   alu_exec dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .zero_o    (zero_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

`ifdef ALU_MUL_EN
   // Accept one MUL, then count edges until valid_o; the product must land
   // exactly 32 edges after the accept edge.
   task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int edges;
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = a;
      data2_i   = b;
      tick();
      valid_i = 1'b0;
      edges   = 0;
      while (valid_o !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      check({name, "_latency"}, 32'(edges), 32'd32);
      check({name, "_data"}, data_o, exp);
      check({name, "_zero"}, {31'd0, zero_o}, {31'd0, exp == 32'd0});
   endtask
`endif

   vec_t vecs[$];

   initial begin
      int bad;
      logic [31:0] last;

      // Back-to-back group: AND, XOR, SUB 5-7, reserved, then the rest.
      vecs.push_back('{C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0});
      vecs.push_back('{C_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
      vecs.push_back('{C_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
      vecs.push_back('{C_RSV, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000});
      vecs.push_back('{C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
      vecs.push_back('{C_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000});
      vecs.push_back('{C_SRA, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF});
      vecs.push_back('{C_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000});
      vecs.push_back('{C_SLL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234});
      vecs.push_back('{C_SRA, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321});
      vecs.push_back('{C_SUB, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000});
`ifndef ALU_MUL_EN
      vecs.push_back('{C_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F});
      vecs.push_back('{C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
`endif
      vecs.push_back('{C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});

      rst_i     = 1'b1;
      valid_i   = 1'b0;
      ALUCtrl_i = 3'b000;
      data1_i   = '0;
      data2_i   = '0;
      tick();
      tick();
      check("rst_data", data_o, 32'h0);
      check("rst_zero", {31'd0, zero_o}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd0);
      rst_i = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, ready_o}, 32'd1);

      // Table: one vector per cycle, so valid_o must stay high throughout.
      foreach (vecs[i]) begin
         valid_i   = 1'b1;
         ALUCtrl_i = vecs[i].code;
         data1_i   = vecs[i].a;
         data2_i   = vecs[i].b;
         #1;
         check($sformatf("vec%0d_ready", i), {31'd0, ready_o}, 32'd1);
         tick();
         check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, 32'd1);
         check($sformatf("vec%0d_data", i), data_o, vecs[i].exp);
         check($sformatf("vec%0d_zero", i), {31'd0, zero_o}, {31'd0, vecs[i].exp == 32'd0});
      end
      last    = vecs[vecs.size()-1].exp;
      valid_i = 1'b0;
      tick();
      check("idle_valid", {31'd0, valid_o}, 32'd0);
      check("idle_hold", data_o, last);

      // Reset wins over a simultaneous request.
      rst_i     = 1'b1;
      valid_i   = 1'b1;
      ALUCtrl_i = C_ADD;
      data1_i   = 32'h1;
      data2_i   = 32'h1;
      tick();
      check("rstprio_valid", {31'd0, valid_o}, 32'd0);
      check("rstprio_data", data_o, 32'h0);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      tick();
      check("rstprio_noaccept", {31'd0, valid_o}, 32'd0);

`ifdef ALU_MUL_EN
      // Iterative MUL: busy for 32 cycles, inputs ignored while busy.
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = 32'h0001_0003;
      data2_i   = 32'h0002_0005;
      tick();
      check("mul_t0_ready", {31'd0, ready_o}, 32'd0);
      check("mul_t0_valid", {31'd0, valid_o}, 32'd0);
      ALUCtrl_i = C_ADD;
      data1_i   = 32'hFFFF_FFFF;
      data2_i   = 32'hFFFF_FFFF;
      bad = 0;
      for (int k = 1; k < 32; k++) begin
         tick();
         if (ready_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'h0) bad++;
      end
      check("mul_busy_cycles_bad", 32'(bad), 32'd0);
      valid_i = 1'b0;
      tick();
      check("mul_done_valid", {31'd0, valid_o}, 32'd1);
      check("mul_done_data", data_o, 32'h000B_000F);
      check("mul_done_zero", {31'd0, zero_o}, 32'd0);
      check("mul_done_ready", {31'd0, ready_o}, 32'd1);
      // A request in the completion cycle is accepted.
      valid_i   = 1'b1;
      ALUCtrl_i = C_ADD;
      data1_i   = 32'd2;
      data2_i   = 32'd3;
      tick();
      valid_i = 1'b0;
      check("after_mul_valid", {31'd0, valid_o}, 32'd1);
      check("after_mul_data", data_o, 32'd5);
      tick();
      check("after_mul_pulse", {31'd0, valid_o}, 32'd0);

      // Reset during iteration 10 aborts the multiply.
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = 32'd3;
      data2_i   = 32'd5;
      tick();
      valid_i = 1'b0;
      repeat (9) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      check("abort_data", data_o, 32'h0);
      check("abort_zero", {31'd0, zero_o}, 32'd1);
      check("abort_valid", {31'd0, valid_o}, 32'd0);
      check("abort_ready", {31'd0, ready_o}, 32'd1);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (valid_o !== 1'b0) bad++;
      end
      check("abort_no_valid", 32'(bad), 32'd0);

      run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      run_mul("mul_by0", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
      run_mul("mul_msb", 32'h8000_0001, 32'h0000_0003, 32'h8000_0003);
`else
      // Combinational MUL: result next cycle, ready never drops.
      valid_i   = 1'b1;
      ALUCtrl_i = C_MUL;
      data1_i   = 32'h0001_0003;
      data2_i   = 32'h0002_0005;
      tick();
      valid_i = 1'b0;
      check("mul1c_ready", {31'd0, ready_o}, 32'd1);
      check("mul1c_valid", {31'd0, valid_o}, 32'd1);
      check("mul1c_data", data_o, 32'h000B_000F);
      tick();
      check("mul1c_pulse", {31'd0, valid_o}, 32'd0);
      check("mul1c_hold", data_o, 32'h000B_000F);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
